bus_arbiter3: RTL

// Round-robin arbiter sharing one 32-bit bus path among three requesters (0: instr fetch,
// 1: load/store, 2: debug/DMA). Its registered O_sel drives the select of the 3-input

---
 rtl/bus_arbiter3.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter3.sv
// bus_arbiter3: three-way arbiter for one shared 32-bit bus path.
// Requesters: 0 = instruction fetch, 1 = load/store, 2 = debug/DMA.
// Its registered O_sel drives the select of the path's 3-input operand mux:
// 00/01/10 pick requester 0/1/2, and 11 means no owner (the mux outputs 0).
// A grant is held until the slave acks or until TIMEOUT_CYCLES grant cycles
// have passed. Every grant is followed by at least one idle turnaround cycle.
//
// Ports:
//   I_clk      in   1  clock, rising edge
//   I_rst      in   1  synchronous reset, active low
//   I_req      in   3  level requests, bit i = requester i
//   I_ack      in   1  slave completion, only looked at while O_busy = 1
//   O_gnt      out  3  one-hot grant, registered, 000 when idle
//   O_sel      out  2  mux select, registered, 11 when idle
//   O_busy     out  1  bus owned
//   O_timeout  out  1  one-cycle pulse after a forced release
module bus_arbiter3 #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter bit          FIXED_PRIO     = 1'b0
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [2:0] I_req,
  input  logic       I_ack,
  output logic [2:0] O_gnt,
  output logic [1:0] O_sel,
  output logic       O_busy,
  output logic       O_timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam bit                   TimeoutEn = (TIMEOUT_CYCLES != 0);
  // Only used when TimeoutEn is set, so the wrap for TIMEOUT_CYCLES = 0 is harmless.
  localparam logic [CNT_WIDTH-1:0] CntLast   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]           SelNone   = 2'b11;

  state_e               state_q, state_d;
  logic [2:0]           gnt_q, gnt_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           ptr_q, ptr_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0] scan0, scan1, scan2;
  logic [1:0] winner;
  logic       release_bus;

  // Pointer arithmetic modulo 3. The 2 -> 0 wrap is an explicit compare so
  // the value 3 can never appear.
  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] idx);
    logic bit_val;
    bit_val = 1'b0;
    unique case (idx)
      2'd0:    bit_val = r[0];
      2'd1:    bit_val = r[1];
      2'd2:    bit_val = r[2];
      default: bit_val = 1'b0;
    endcase
    return bit_val;
  endfunction

  // Winner: first set request scanning ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    scan0  = ptr_q;
    scan1  = wrap_inc(scan0);
    scan2  = wrap_inc(scan1);
    winner = scan2;
    if (req_at(I_req, scan0)) begin
      winner = scan0;
    end else if (req_at(I_req, scan1)) begin
      winner = scan1;
    end
  end

  // An ack in the same cycle as the last allowed grant cycle counts as an ack.
  assign release_bus = I_ack || (TimeoutEn && (cnt_q == CntLast));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_d = 3'b000;
        sel_d = SelNone;
        if (|I_req) begin
          state_d = StGrant;
          gnt_d   = 3'b001 << winner;
          sel_d   = winner;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        // Grant is held regardless of I_req; only ack or timeout releases it.
        if (release_bus) begin
          state_d   = StIdle;
          gnt_d     = 3'b000;
          sel_d     = SelNone;
          timeout_d = ~I_ack;
          ptr_d     = FIXED_PRIO ? 2'd0 : wrap_inc(sel_q);
          cnt_d     = '0;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 3'b000;
        sel_d   = SelNone;
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state_q   <= StIdle;
      gnt_q     <= 3'b000;
      sel_q     <= SelNone;
      ptr_q     <= 2'd0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign O_gnt     = gnt_q;
  assign O_sel     = sel_q;
  assign O_busy    = (state_q == StGrant);
  assign O_timeout = timeout_q;

endmodule
